// File: rtl/cover_pkg.sv
// Shared types for the toggle-coverage scheduler: index type and FSM states.
package cover_pkg;

  localparam int unsigned COVER_IDX_W = 64;

  typedef logic [COVER_IDX_W-1:0] cover_index_t;

  typedef enum logic [0:0] {RUN, CLEAR} sched_state_t;

endpackage

// File: rtl/cover_prio_enc.sv
// Combinational lowest-set-bit priority encoder with a found flag.
module cover_prio_enc #(
  parameter int unsigned WIDTH = 39,
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/cover_toggle_sched.sv
// Records first-time toggle hits and reports each covered point exactly once,
// one index per handshake, lowest bit first.
module cover_toggle_sched
  import cover_pkg::*;
#(
  parameter int unsigned WIDTH       = 39,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 8065
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         enable,
  input  logic                         clear_req,
  output logic                         clear_done,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered
);

  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  sched_state_t     state_q;
  logic [WIDTH-1:0] covered_q, pending_q, pending_d, new_hits;
  logic             out_valid_q, clear_done_q;
  cover_index_t     out_index_q;
  logic [CNT_W-1:0] count_q, hit_cnt;
  logic [IDX_W-1:0] low_idx;
  logic             low_found, load, clear_fin;

  cover_prio_enc #(
    .WIDTH(WIDTH)
  ) u_prio_enc (
    .vec  (pending_q),
    .idx  (low_idx),
    .found(low_found)
  );

  always_comb begin
    new_hits = '0;
    if (state_q == RUN && enable) new_hits = valid & ~covered_q;
    hit_cnt = '0;
    for (int i = 0; i < WIDTH; i++) hit_cnt = hit_cnt + CNT_W'(new_hits[i]);
    load      = !out_valid_q || out_ready;
    // The drained bit comes from the old pending mask; it is already covered,
    // so it can never collide with this cycle's new hits.
    pending_d = pending_q | new_hits;
    if (load && low_found) pending_d[low_idx] = 1'b0;
    clear_fin = (state_q == CLEAR) && (pending_q == '0) && load;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= RUN;
      covered_q    <= '0;
      pending_q    <= '0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      count_q      <= '0;
      clear_done_q <= 1'b0;
    end else begin
      clear_done_q <= clear_fin;
      pending_q    <= pending_d;
      if (load) begin
        out_valid_q <= low_found;
        if (low_found) out_index_q <= cover_index_t'(COVER_INDEX) + cover_index_t'(low_idx);
      end
      if (clear_fin) begin
        covered_q <= '0;
        count_q   <= '0;
        state_q   <= RUN;
      end else begin
        covered_q <= covered_q | new_hits;
        count_q   <= count_q + hit_cnt;
        if (state_q == RUN && clear_req) state_q <= CLEAR;
      end
    end
  end

  assign out_valid     = out_valid_q;
  assign out_index     = out_index_q;
  assign covered_count = count_q;
  assign clear_done    = clear_done_q;
  assign all_covered   = (count_q == CNT_W'(WIDTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      assert (COVER_INDEX + WIDTH <= COVER_TOTAL)
        else $error("COVER_INDEX + WIDTH exceeds COVER_TOTAL");
      if (out_valid_q) begin
        assert (out_index_q < cover_index_t'(COVER_TOTAL))
          else $error("out_index out of range");
      end
      assert ((pending_q & ~covered_q) == '0)
        else $error("pending bit not covered");
    end
  end

endmodule

// File: tb/tb_cover_toggle_sched.sv
// Scoreboard bench for cover_toggle_sched: expected indices are queued at
// stimulus time and popped by a monitor on each accepted transfer.
module tb_cover_toggle_sched;

  localparam int unsigned WIDTH = 39;
  localparam int unsigned CIDX  = 100;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] valid;
  logic             enable, clear_req, clear_done;
  logic             out_valid, out_ready;
  logic [63:0]      out_index;
  logic [5:0]       covered_count;
  logic             all_covered;

  int asserts  = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  cover_toggle_sched #(
    .WIDTH      (WIDTH),
    .COVER_INDEX(CIDX),
    .COVER_TOTAL(8065)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .valid        (valid),
    .enable       (enable),
    .clear_req    (clear_req),
    .clear_done   (clear_done),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .covered_count(covered_count),
    .all_covered  (all_covered)
  );

  always #5 clock = ~clock;

  // Transfer monitor: sampled mid-cycle, transfer happens at the next posedge.
  always @(negedge clock) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      asserts++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL xfer_unexpected: got index %0d, required no transfer", out_index);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (out_index !== e) begin
          failures++;
          $display("FAIL xfer_index: got %0d, required %0d", out_index, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; valid = '0; enable = 1'b1; clear_req = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    asserts++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d outstanding, required 0", name, exp_q.size());
    end
    tick();
    asserts++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: got out_valid %b, required 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    asserts += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, required 0", out_valid); end
    if (out_index !== 64'd0) begin failures++; $display("FAIL rst_index: got %0d, required 0", out_index); end
    if (covered_count !== 6'd0) begin failures++; $display("FAIL rst_count: got %0d, required 0", covered_count); end
    if (clear_done !== 1'b0) begin failures++; $display("FAIL rst_cdone: got %b, required 0", clear_done); end
    if (all_covered !== 1'b0) begin failures++; $display("FAIL rst_all: got %b, required 0", all_covered); end
  endtask

  task automatic test_single();
    do_reset();
    valid = '0; valid[5] = 1'b1;
    exp_q.push_back(CIDX + 5);
    tick();
    valid = '0;
    asserts++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_early: got %b, required 0", out_valid); end
    tick();
    asserts += 2;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %b, required 1", out_valid); end
    if (out_index !== 64'(CIDX + 5)) begin failures++; $display("FAIL single_index: got %0d, required %0d", out_index, CIDX + 5); end
    tick();
    asserts += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL single_once: got %b, required 0", out_valid); end
    if (covered_count !== 6'd1) begin failures++; $display("FAIL single_count: got %0d, required 1", covered_count); end
  endtask

  task automatic test_multi();
    int bits[3] = '{0, 7, 38};
    do_reset();
    valid = '0;
    foreach (bits[i]) begin
      valid[bits[i]] = 1'b1;
      exp_q.push_back(64'(CIDX + bits[i]));
    end
    tick();
    valid = '0;
    asserts++;
    if (covered_count !== 6'd3) begin failures++; $display("FAIL multi_count: got %0d, required 3", covered_count); end
    foreach (bits[i]) begin
      tick();
      asserts++;
      if (out_valid !== 1'b1 || out_index !== 64'(CIDX + bits[i])) begin
        failures++;
        $display("FAIL multi_order: got valid %b index %0d, required valid 1 index %0d",
                 out_valid, out_index, CIDX + bits[i]);
      end
    end
    wait_drain("multi");
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    valid = '0; valid[2] = 1'b1; valid[3] = 1'b1;
    exp_q.push_back(CIDX + 2);
    exp_q.push_back(CIDX + 3);
    tick();
    valid = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      asserts++;
      if (out_valid !== 1'b1 || out_index !== 64'(CIDX + 2)) begin
        failures++;
        $display("FAIL bp_stable: got valid %b index %0d, required valid 1 index %0d",
                 out_valid, out_index, CIDX + 2);
      end
      tick();
    end
    out_ready = 1'b1;
    wait_drain("bp");
  endtask

  task automatic test_dedup();
    do_reset();
    valid = '0; valid[4] = 1'b1;
    exp_q.push_back(CIDX + 4);
    for (int i = 0; i < 20; i++) tick();
    valid = '0;
    tick(); tick(); tick();
    valid[4] = 1'b1;
    tick();
    valid = '0;
    wait_drain("dedup");
    asserts++;
    if (covered_count !== 6'd1) begin failures++; $display("FAIL dedup_count: got %0d, required 1", covered_count); end
  endtask

  task automatic test_clear();
    int n = 0;
    bit seen = 0;
    do_reset();
    out_ready = 1'b0;
    valid = '0;
    for (int b = 10; b < 20; b++) begin
      valid[b] = 1'b1;
      exp_q.push_back(64'(CIDX + b));
    end
    tick();
    valid = '0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    valid[20] = 1'b1;
    tick();
    valid = '0;
    out_ready = 1'b1;
    while (!seen && n < 60) begin
      tick();
      n++;
      if (clear_done === 1'b1) seen = 1;
    end
    asserts += 3;
    if (!seen) begin failures++; $display("FAIL clr_done: got no pulse, required one pulse"); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL clr_drained: got %0d outstanding, required 0", exp_q.size()); end
    if (covered_count !== 6'd0) begin failures++; $display("FAIL clr_count: got %0d, required 0", covered_count); end
    tick();
    asserts++;
    if (clear_done !== 1'b0) begin failures++; $display("FAIL clr_pulse: got %b, required 0", clear_done); end
    valid[20] = 1'b1;
    exp_q.push_back(CIDX + 20);
    tick();
    valid = '0;
    wait_drain("clr_rehit");
    asserts++;
    if (covered_count !== 6'd1) begin failures++; $display("FAIL clr_recount: got %0d, required 1", covered_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    valid = '0;
    for (int b = 0; b < 10; b++) valid[b] = 1'b1;
    exp_q.push_back(CIDX + 0);
    tick();
    valid = '0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    tick();
    asserts += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b, required 0", out_valid); end
    if (covered_count !== 6'd0) begin failures++; $display("FAIL rmid_count: got %0d, required 0", covered_count); end
    reset = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    valid = '1;
    for (int b = 0; b < WIDTH; b++) exp_q.push_back(64'(CIDX + b));
    tick();
    valid = '0;
    asserts += 2;
    if (all_covered !== 1'b1) begin failures++; $display("FAIL all_cov: got %b, required 1", all_covered); end
    if (covered_count !== 6'(WIDTH)) begin failures++; $display("FAIL all_count: got %0d, required %0d", covered_count, WIDTH); end
    wait_drain("all");
  endtask

  initial begin
    reset = 1'b0; valid = '0; enable = 1'b1; clear_req = 1'b0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_dedup();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
